// File: rtl/motor_frame_tx.sv
// Snapshots four motor bytes on start and streams SYNC, m1..m4 (plus an optional
// checksum byte when FRAME_CHECKSUM_EN is defined) through a send/done UART handshake.
module motor_frame_tx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         GAP_CYCLES     = 0,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] motor1,
    input  logic [7:0] motor2,
    input  logic [7:0] motor3,
    input  logic [7:0] motor4,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    // Handshake: tx_send is a one-cycle strobe with tx_data valid in that cycle;
    // the transmitter answers with a one-cycle tx_done once the byte is shifted out.
    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    state_t      state, next_state;
    logic [2:0]  idx, next_idx;
    logic [7:0]  snap1, snap2, snap3, snap4;
    logic [15:0] gap_cnt, tmo_cnt;
    logic        done_pulse, err_pulse;
    logic [7:0]  next_byte;

    always_comb begin
        next_state = state;
        next_idx   = idx;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SEND;
                    next_idx   = 3'd0;
                end
            end
            SEND: next_state = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (idx == LAST_IDX) begin
                        next_state = IDLE;
                        done_pulse = 1'b1;
                    end else begin
                        next_idx   = idx + 3'd1;
                        next_state = (GAP_CYCLES > 0) ? GAP : SEND;
                    end
                end else if (TIMEOUT_CYCLES > 0 && int'(tmo_cnt) + 1 >= TIMEOUT_CYCLES) begin
                    // tmo_cnt counts cycles since the tx_send cycle began
                    next_state = IDLE;
                    err_pulse  = 1'b1;
                end
            end
            GAP: begin
                if (int'(gap_cnt) + 1 >= GAP_CYCLES) next_state = SEND;
            end
            default: next_state = IDLE;
        endcase
    end

    // Index 0 never needs the snapshot, so a same-edge capture on start is safe.
    always_comb begin
        next_byte = SYNC_BYTE;
        case (next_idx)
            3'd1: next_byte = snap1;
            3'd2: next_byte = snap2;
            3'd3: next_byte = snap3;
            3'd4: next_byte = snap4;
`ifdef FRAME_CHECKSUM_EN
            3'd5: next_byte = snap1 + snap2 + snap3 + snap4;
`endif
            default: next_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            snap1      <= 8'd0;
            snap2      <= 8'd0;
            snap3      <= 8'd0;
            snap4      <= 8'd0;
            gap_cnt    <= 16'd0;
            tmo_cnt    <= 16'd0;
            tx_data    <= 8'd0;
            tx_send    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            if (state == IDLE && start) begin
                snap1 <= motor1;
                snap2 <= motor2;
                snap3 <= motor3;
                snap4 <= motor4;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
            else              gap_cnt <= 16'd0;
            if (next_state == SEND)                 tmo_cnt <= 16'd0;
            else if (state == SEND || state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
            if (next_state == SEND) tx_data <= next_byte;
            tx_send    <= (next_state == SEND);
            busy       <= (next_state != IDLE);
            frame_done <= done_pulse;
            frame_err  <= err_pulse;
        end
    end

endmodule

// File: doc/motor_frame_tx.md
Name: motor_frame_tx

Overview:
- Transmit-side counterpart of the four-motor speed deserializer.
- Snapshots four 8-bit motor values on a start request and sends them as one framed byte stream through the UART transmitter's byte handshake.
- Frame order: SYNC_BYTE, motor1, motor2, motor3, motor4, plus an optional checksum byte.
- Used to report commanded or measured motor speeds back to the host.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- GAP_CYCLES, 0, idle clk cycles inserted after each tx_done before the next byte. 0 = back-to-back.
- TIMEOUT_CYCLES, 65535, maximum clk cycles to wait for tx_done per byte before aborting. 0 disables the timeout. Counter is 16 bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request one frame; sampled only in IDLE
- motor1  input  8  speed value 1
- motor2  input  8  speed value 2
- motor3  input  8  speed value 3
- motor4  input  8  speed value 4
- tx_data  output  8  byte presented to UART transmitter
- tx_send  output  1  one-cycle strobe: UART transmitter latches tx_data
- tx_done  input  1  one-cycle pulse from UART: current byte fully shifted out
- busy  output  1  high whenever FSM not in IDLE
- frame_done  output  1  one-cycle pulse: frame completed normally
- frame_err  output  1  one-cycle pulse: frame aborted by timeout

Behaviour:
- Reset (async, any time, including mid-frame):
  - State returns to IDLE.
  - tx_data=0, tx_send=0, busy=0, frame_done=0, frame_err=0.
  - Snapshot registers, byte index, gap and timeout counters all cleared.
  - No frame_done or frame_err is generated for an aborted frame.
- States: IDLE, SEND, WAIT, GAP.
- IDLE:
  - On start=1 at an edge, capture motor1..4 into snapshot registers and clear byte index to 0.
  - Go to SEND.
  - Motor inputs are ignored after capture.
- SEND (exactly one cycle):
  - tx_send=1; tx_data = byte[index].
  - Clear timeout counter; go to WAIT.
  - tx_data holds that value until the next SEND.
- WAIT:
  - tx_done is ignored during the SEND cycle itself.
  - On tx_done=1 with the last byte: go to IDLE and pulse frame_done in the same cycle that busy falls.
  - On tx_done=1 with bytes remaining: increment index, then go to GAP if GAP_CYCLES>0, else SEND.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without tx_done: go to IDLE and pulse frame_err; frame_done is not asserted.
- GAP: count GAP_CYCLES cycles, then SEND.
- Byte sequence: index 0 = SYNC_BYTE, 1..4 = snapshot motor1..motor4, 5 = checksum (only when enabled).
  - Last index is 4 without checksum, 5 with it.
- Latency: start sampled at edge k gives tx_send high during the cycle after edge k, with tx_data=SYNC_BYTE.
- start while busy is ignored, not queued.
  - start in the frame_done cycle is accepted, since the FSM is already in IDLE.
- tx_done in IDLE or GAP is ignored.
- Outputs tx_send, frame_done and frame_err are registered and mutually exclusive in any cycle.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- Defined: a sixth byte is appended, equal to (m1+m2+m3+m4) mod 256 over the snapshot values, with SYNC_BYTE excluded. Overflow wraps silently. Frame is 6 bytes.
- Undefined: frame is 5 bytes; no checksum logic is built.

Test Plan:
- Basic frame: motors 0x10,0x20,0x30,0x40, start pulse, tx_done 10 cycles after each tx_send.
  - Expect tx_data sequence A5,10,20,30,40 (plus A0 with FRAME_CHECKSUM_EN).
  - Expect first tx_send one cycle after start, and frame_done exactly once with busy falling in the same cycle.
- Snapshot and busy start: change motors to 0xFF after start; pulse start again mid-frame.
  - Expect original values sent; only one frame, one frame_done.
- Checksum wrap (FRAME_CHECKSUM_EN): motors 0xFF,0xFF,0x02,0x01 -> checksum byte 0x01.
- Timeout: TIMEOUT_CYCLES=20, withhold tx_done after the second byte.
  - Expect frame_err pulse 20 cycles after that tx_send, busy=0, no frame_done.
  - Next start sends a complete frame starting with SYNC_BYTE.
- Gap and reset: GAP_CYCLES=3.
  - Expect exactly 3 idle cycles between each tx_done and the next tx_send.
  - Assert rst during WAIT of byte 2: outputs clear immediately (async), no frame_done; the following start gives a full frame from index 0.
